// File: rtl/qupls4_reg_tag_freer_pkg.sv
// qupls4_reg_tag_freer_pkg: shared register-tag types and the quarter find-first-one helper
package qupls4_reg_tag_freer_pkg;
  localparam int PREGS = 512;
  localparam int QDEPTH_DEF = 32;
  localparam int QBITS = PREGS / 4;
  typedef logic [$clog2(PREGS)-1:0] pregno_t;
  typedef logic [$clog2(QDEPTH_DEF):0] qfreer_cnt_t;
  typedef logic [$clog2(QBITS)-1:0] qidx_t;
  typedef enum logic {IDLE, ACTIVE} freer_state_e;
  function automatic qidx_t ffo_q(input logic [QBITS-1:0] b);
    ffo_q = '0;
    for (int i = QBITS - 1; i >= 0; i--)
      if (b[i]) ffo_q = qidx_t'(i);
  endfunction
endpackage

// File: rtl/qupls4_reg_tag_freer_compact.sv
// qupls4_reg_tag_freer_compact: packs valid commit lanes to the low end, lowest lane first
module qupls4_reg_tag_freer_compact
  import qupls4_reg_tag_freer_pkg::*;
#(
  parameter int NCOMMIT = 8
) (
  input  pregno_t [NCOMMIT-1:0]       tag_i,
  input  logic    [NCOMMIT-1:0]       v_i,
  output pregno_t [NCOMMIT-1:0]       tag_o,
  output logic    [$clog2(NCOMMIT):0] cnt_o
);
  localparam int CW = $clog2(NCOMMIT) + 1;
  always_comb begin
    int p;
    p = 0;
    tag_o = '0;
    for (int i = 0; i < NCOMMIT; i++)
      if (v_i[i]) begin
        tag_o[p] = tag_i[i];
        p = p + 1;
      end
    cnt_o = CW'(p);
  end
endmodule

// File: rtl/qupls4_reg_tag_freer.sv
// qupls4_reg_tag_freer: merges committed tags (FIFO) and flushed tags (bitmap) into the free port
module qupls4_reg_tag_freer
  import qupls4_reg_tag_freer_pkg::*;
#(
  parameter int NCOMMIT = 8,
  parameter int NFTAGS  = 4,
  parameter int QDEPTH  = 32,
  parameter int STARVE  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  pregno_t [NCOMMIT-1:0]   cmt_tag,
  input  logic    [NCOMMIT-1:0]   cmt_v,
  output logic                    cmt_stall,
  input  logic                    bulk_req,
  input  logic    [PREGS-1:0]     bulk_list,
  output pregno_t [NFTAGS-1:0]    tags2free,
  output logic    [NFTAGS-1:0]    freevals,
  output logic                    busy
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE + 1);
  localparam int QW = PREGS / NFTAGS;
  pregno_t mem_q [QDEPTH];
  pregno_t mem_d [QDEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, push, pop;
  logic [PREGS-1:0] bmap_q, bmap_d, clr;
  logic [SW-1:0] starve_q, starve_d;
  pregno_t [NFTAGS-1:0] tags_q, tags_d;
  logic [NFTAGS-1:0] fv_q, fv_d;
  pregno_t [NCOMMIT-1:0] ctag;
  logic [$clog2(NCOMMIT):0] ccnt;
  logic fifo_mode, bulk_mode;
  freer_state_e state;
  qupls4_reg_tag_freer_compact #(.NCOMMIT(NCOMMIT)) u_compact (
    .tag_i(cmt_tag),
    .v_i  (cmt_v),
    .tag_o(ctag),
    .cnt_o(ccnt)
  );
  always_comb begin
    state = (count_q == '0 && bmap_q == '0) ? IDLE : ACTIVE;
    busy = state == ACTIVE;
    cmt_stall = (CW'(QDEPTH) - count_q) < CW'(NCOMMIT);
    fifo_mode = count_q != '0 && starve_q < SW'(STARVE);
    bulk_mode = !fifo_mode && bmap_q != '0;
    push = cmt_stall ? '0 : CW'(ccnt);
    pop = !fifo_mode ? '0 : count_q < CW'(NFTAGS) ? count_q : CW'(NFTAGS);
    mem_d = mem_q;
    for (int j = 0; j < NCOMMIT; j++)
      if (CW'(j) < push) mem_d[wptr_q + AW'(j)] = ctag[j];
    clr = '0;
    tags_d = tags_q;
    fv_d = '0;
    for (int n = 0; n < NFTAGS; n++)
      if (fifo_mode && CW'(n) < pop) begin
        tags_d[n] = mem_q[rptr_q + AW'(n)];
        fv_d[n] = 1'b1;
      end else if (bulk_mode && bmap_q[n*QW +: QW] != '0) begin
        tags_d[n] = pregno_t'(n * QW) | pregno_t'(ffo_q(bmap_q[n*QW +: QW]));
        clr[n*QW + int'(ffo_q(bmap_q[n*QW +: QW]))] = 1'b1;
        fv_d[n] = 1'b1;
      end
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + push - pop;
    // a bit freed this edge and re-requested on the same edge must survive
    bmap_d = (bmap_q & ~clr) | (bulk_req ? bulk_list : '0);
    starve_d = (fifo_mode && bmap_q != '0) ? starve_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      bmap_q <= '0;
      starve_q <= '0;
      tags_q <= '0;
      fv_q <= '0;
    end else begin
      assert (count_d <= CW'(QDEPTH)) else $error("tag freer FIFO overflow");
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      bmap_q <= bmap_d;
      starve_q <= starve_d;
      tags_q <= tags_d;
      fv_q <= fv_d;
    end
  end
  assign tags2free = tags_q;
  assign freevals = fv_q;
endmodule
